// File: rtl/sim_exit_monitor.sv
// End-of-test monitor: PC/tohost-driven PASS/FAIL/TIMEOUT FSM plus a UART byte sniffer FIFO.
// Optional tohost decode is enabled by defining SIM_MONITOR_TOHOST_EN.
module sim_exit_monitor #(
  parameter logic [31:0] PASS_PC        = 32'h80000130,
  parameter logic [31:0] FAIL_PC        = 32'h80000134,
  parameter logic [31:0] UART_ADDR      = 32'h92000000,
  parameter logic [31:0] TOHOST_ADDR    = 32'h80001000,
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned CNT_W          = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      d_addr_i,
  input  logic [31:0]      d_data_wr_i,
  input  logic [3:0]       d_wr_i,
  output logic             uart_hit_o,
  output logic             uart_valid_o,
  output logic [7:0]       uart_data_o,
  input  logic             uart_ready_i,
  output logic             uart_drop_o,
  output logic [2:0]       state_o,
  output logic             done_o,
  output logic [CNT_W-1:0] cycle_count_o,
  output logic [30:0]      exit_code_o
);

  localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_t;

  state_t           state_q;
  logic             done_q;
  logic [CNT_W-1:0] cnt_q;
  logic [30:0]      exit_code_q;
  logic             timeout_hit_s;
  logic             tohost_pass_s;
  logic             tohost_fail_s;

`ifdef SIM_MONITOR_TOHOST_EN
  logic tohost_wr_s;
  assign tohost_wr_s   = (d_wr_i == 4'hF) && (d_addr_i == TOHOST_ADDR);
  assign tohost_pass_s = tohost_wr_s && (d_data_wr_i == 32'd1);
  assign tohost_fail_s = tohost_wr_s && d_data_wr_i[0] && (d_data_wr_i != 32'd1);
`else
  logic unused_s;
  assign tohost_pass_s = 1'b0;
  assign tohost_fail_s = 1'b0;
  assign unused_s      = ^TOHOST_ADDR;
`endif

  assign timeout_hit_s = (TIMEOUT_CYCLES != 32'd0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Run-state FSM; terminal states hold until reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      done_q      <= 1'b0;
      exit_code_q <= 31'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable_i) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (pc_i == PASS_PC) begin
            state_q <= ST_PASS;
            done_q  <= 1'b1;
          end else if (pc_i == FAIL_PC) begin
            state_q <= ST_FAIL;
            done_q  <= 1'b1;
          end else if (tohost_pass_s) begin
            state_q <= ST_PASS;
            done_q  <= 1'b1;
          end else if (tohost_fail_s) begin
            state_q     <= ST_FAIL;
            done_q      <= 1'b1;
            exit_code_q <= d_data_wr_i[31:1];
          end else if (timeout_hit_s) begin
            state_q <= ST_TIMEOUT;
            done_q  <= 1'b1;
          end
        end
        ST_PASS, ST_FAIL, ST_TIMEOUT: begin
          state_q <= state_q;
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Cycle counter advances only while running, including the terminating edge.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (state_q == ST_RUN) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign state_o       = state_q;
  assign done_o        = done_q;
  assign cycle_count_o = cnt_q;
  assign exit_code_o   = exit_code_q;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             drop_q, drop_d;
  logic             empty_s, full_s, push_req_s, push_s, pop_s;

  assign uart_hit_o = (d_wr_i != 4'h0) && (d_addr_i == UART_ADDR);
  assign empty_s    = (wr_ptr_q == rd_ptr_q);
  // Same slot index with differing wrap bits means every entry is occupied.
  assign full_s     = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                      (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign push_req_s = uart_hit_o && d_wr_i[0];
  assign pop_s      = !empty_s && uart_ready_i;
  assign push_s     = push_req_s && (!full_s || pop_s);

  // FIFO pointer and drop-flag next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    drop_d   = drop_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_req_s && !push_s) begin
      drop_d = 1'b1;
    end else begin
      drop_d = drop_q;
    end
  end

  // FIFO pointer and drop-flag registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      drop_q   <= drop_d;
    end
  end

  // FIFO storage; contents need no reset because the pointers define occupancy.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q[IDX_W-1:0]] <= d_data_wr_i[7:0];
    end
  end

  assign uart_valid_o = !empty_s;
  assign uart_data_o  = empty_s ? 8'h00 : mem_q[rd_ptr_q[IDX_W-1:0]];
  assign uart_drop_o  = drop_q;

endmodule

// File: doc/sim_exit_monitor.md
# sim_exit_monitor

Parametrised, synthesizable end-of-test monitor for `riscv_core` simulation and FPGA bring-up. It replaces ad-hoc bench logic: it watches the fetch PC and the data-write bus, and declares PASS, FAIL or TIMEOUT through a sticky state machine. It also sniffs UART-register writes into a byte FIFO drained by a ready/valid port, and raises a hit flag so the top level can redirect those writes away from TCM.

## Interface
Parameters:
- `PASS_PC`, 32'h80000130, fetch PC that signals pass
- `FAIL_PC`, 32'h80000134, fetch PC that signals fail
- `UART_ADDR`, 32'h92000000, UART TX register address
- `TOHOST_ADDR`, 32'h80001000, tohost word address (used only with the macro)
- `TIMEOUT_CYCLES`, 200000, run cycles before timeout; 0 disables timeout
- `FIFO_DEPTH`, 16, UART FIFO entries; power of two, ≥2
- `CNT_W`, 64, cycle counter width

Ports:
- `clk_i` in 1: clock; single clock domain.
- `rst_i` in 1: synchronous, active-low reset.
- `enable_i` in 1: level; starts monitoring.
- `pc_i` in 32: fetch PC (`mem_i_pc_o`).
- `d_addr_i` in 32: data address.
- `d_data_wr_i` in 32: write data.
- `d_wr_i` in 4: byte write strobes.
- `uart_hit_o` out 1: combinational; `d_wr_i!=0 && d_addr_i==UART_ADDR`.
- `uart_valid_o` out 1: FIFO non-empty.
- `uart_data_o` out 8: FIFO head byte.
- `uart_ready_i` in 1: consumer accepts the head byte.
- `uart_drop_o` out 1: sticky; a byte was lost.
- `state_o` out 3: 0 IDLE, 1 RUN, 2 PASS, 3 FAIL, 4 TIMEOUT.
- `done_o` out 1: `state_o` ≥ 2.
- `cycle_count_o` out CNT_W: cycles spent in RUN.
- `exit_code_o` out 31: tohost fail code.

## Operation
- IDLE→RUN when `enable_i`=1. `enable_i` is ignored once the block has left IDLE.
- In RUN, evaluated in priority order:
  - `pc_i==PASS_PC` → PASS.
  - else `pc_i==FAIL_PC` → FAIL.
  - else a tohost event (see Configuration) → PASS or FAIL.
  - else `TIMEOUT_CYCLES!=0 && cycle_count_o==TIMEOUT_CYCLES` → TIMEOUT.
- PASS, FAIL and TIMEOUT are terminal: they hold until reset and ignore further PC matches.
- `cycle_count_o` increments by 1 on every RUN cycle, wraps modulo 2^CNT_W, and freezes in every other state.
- UART capture is active in every state after reset, including IDLE and terminal states.
  - A push occurs when `uart_hit_o && d_wr_i[0]`; the byte is `d_data_wr_i[7:0]`.
  - A hit without `d_wr_i[0]` is ignored.
- FIFO pop occurs when `uart_valid_o && uart_ready_i`. It is first-word-fall-through, and bytes leave in write order.
- Full FIFO:
  - A push with a simultaneous pop is accepted.
  - A push without a pop is dropped, and `uart_drop_o` is set until reset.
- Empty FIFO: a pop cannot occur because `uart_valid_o`=0.
- Pointers are log2(FIFO_DEPTH)+1 bits, so full and empty are distinguished by the extra MSB.

## Timing
- Reset values: `state_o`=0, `done_o`=0, `cycle_count_o`=0, `uart_valid_o`=0, `uart_data_o`=0, `uart_drop_o`=0, `exit_code_o`=0. `uart_hit_o` is combinational and not reset.
- Reset asserted mid-run, on any cycle: the next edge returns every register to its reset value and empties the FIFO.
- IDLE→RUN: `enable_i` sampled high at edge N gives `state_o`=RUN after edge N. `cycle_count_o` is 1 after edge N+1.
- PC match: `pc_i` matching at edge N gives `state_o`/`done_o` updated after edge N, i.e. 1-cycle latency.
- Timeout: declared at the edge where `cycle_count_o`==TIMEOUT_CYCLES, i.e. after TIMEOUT_CYCLES+1 RUN cycles. The count then freezes at TIMEOUT_CYCLES+1.
- UART: a write at edge N gives `uart_valid_o`=1 with the byte after edge N. A pop at edge N presents the next byte or deasserts valid after edge N.

## Configuration
- `SIM_MONITOR_TOHOST_EN` defined:
  - A RUN-state write with `d_wr_i==4'hF` and `d_addr_i==TOHOST_ADDR` is decoded with value V.
  - V==1 → PASS.
  - V odd and ≠1 → FAIL, with `exit_code_o`=V[31:1] latched.
  - V even → ignored.
- `SIM_MONITOR_TOHOST_EN` undefined: tohost decode is absent, `TOHOST_ADDR` is ignored, and `exit_code_o` is constant 0.

## Test plan
- Reset low 3 cycles, `enable_i`=1, then `pc_i`=32'h80000130 at run cycle 10 → `state_o`=2, `done_o`=1, `cycle_count_o`=10 and frozen. A later `pc_i`=FAIL_PC leaves state 2.
- `pc_i`=FAIL_PC in the same cycle as a valid tohost write of 1 (macro on) → FAIL (state 3), since the PC match has priority.
- TIMEOUT_CYCLES=20, no matches → TIMEOUT after edge 21 of RUN, `cycle_count_o`=21. With TIMEOUT_CYCLES=0 and 1000 cycles, state stays RUN.
- `uart_ready_i`=0, 18 writes of bytes 0x41..0x52 at depth 16 → bytes 0x41..0x50 stored and `uart_drop_o`=1. Then `uart_ready_i`=1 → 16 bytes drained in order, after which `uart_valid_o`=0.
- FIFO full, push 0x5A and pop in the same cycle → no drop, and 0x5A emerges last. A write to UART_ADDR with `d_wr_i`=4'b0010 → `uart_hit_o`=1 but no push.
- Macro on: tohost write of 32'h0000000B → FAIL with `exit_code_o`=5; write of 2 → ignored. Reset mid-RUN with 3 bytes queued → all outputs return to reset values next cycle.
